dm_access_unit: RTL
===================

Name: dm_access_unit

Overview:
- Memory-stage front end that sits directly upstream of the word-wide data memory (DM) and feeds its address, write-data and write-enable.
- Converts pipeline load/store requests (word, half, byte; signed and unsigned) into DM word transactions.
- Sub-word stores use a two-cycle read-modify-write and stall the pipeline for one cycle.
- Sub-word loads are extracted and extended from the DM read word. Misaligned accesses are flagged and never reach DM.

Parameters:
- ADDR_W, 32, byte-address width presented by the pipeline.
- DATA_W, 32, word width; fixed at 32, with byte lanes at [7:0] up to [31:24].

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- mem_op  in  4  request opcode (see package); 0 = NONE.
- pc  in  32  PC of the requesting instruction; forwarded to DM for store logging.
- address  in  32  byte address of the request.
- writedata  in  32  store data, right-aligned (sb uses [7:0], sh uses [15:0]).
- stall  out  1  high = pipeline must hold mem_op/address/writedata/pc stable next cycle.
- addr_exc  out  1  high = current request is misaligned; request suppressed.
- loaddata  out  32  extended load result for WB.
- dm_address  out  32  to DM address; word-aligned ({address[31:2],2'b00}).
- dm_writedata  out  32  to DM write data.
- dm_memWrite  out  1  to DM write enable.
- dm_memRead  out  1  to DM read enable.
- dm_pc  out  32  to DM pc.
- dm_readdata  in  32  from DM readdata (combinational read).

Behaviour:
- FSM states: IDLE, RMW_WR.
- Reset: state = IDLE, merge register = 0. All registered outputs are 0.
- Misalignment: LW/SW with address[1:0] != 0, or LH/LHU/SH with address[0] = 1.
  - addr_exc = 1 in the same cycle (combinational).
  - dm_memWrite = 0, loaddata = 0, stall = 0, state unchanged.
- IDLE, op NONE: all dm_* enables = 0, stall = 0.
- IDLE, LW/LH/LHU/LB/LBU (aligned): dm_memRead = 1. loaddata is combinational in the same cycle (zero added latency).
  - Lane selection by address[1:0] (LH by address[1]); little-endian, lane 0 = bits [7:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- IDLE, SW (aligned): dm_memWrite = 1 and dm_writedata = writedata in the same cycle. Single cycle, no stall.
- IDLE, SB/SH (aligned): dm_memRead = 1, dm_memWrite = 0, stall = 1.
  - Latch the merged word (dm_readdata with the target lane replaced by writedata[7:0] or [15:0]) into merge_q on the clock edge.
  - Go to RMW_WR.
- RMW_WR:
  - dm_memWrite = 1, dm_writedata = merge_q, dm_address = {address[31:2],2'b00}, stall = 0.
  - Return to IDLE on the next edge.
  - The pipeline has held the request, so address/pc are still valid.
- Total cost: a sub-word store takes exactly 2 cycles with 1 stall cycle. A back-to-back sub-word store starts its own RMW in the following IDLE cycle.
- Reset asserted in RMW_WR: the write is suppressed that cycle (dm_memWrite forced 0 while reset = 1), and the state returns to IDLE.
- dm_pc = pc in every cycle.
- Unknown opcodes (9–15) behave as NONE.

Decomposition:
- Package mem_pkg holds:
  - op constants: NONE=0, LW=1, LH=2, LHU=3, LB=4, LBU=5, SW=6, SH=7, SB=8;
  - state encoding IDLE=0, RMW_WR=1.
- One natural sub-module, load_ext: combinational lane select plus sign/zero extension (inputs: word, address[1:0], op).
- The FSM and merge logic stay in dm_access_unit.

Test Plan:
- Reset: hold reset 2 cycles with mem_op = SB → stall = 0, dm_memWrite = 0, state IDLE. After reset, merge_q = 0.
- SW to 0x10 with data 0x11223344, then LW from 0x10 → one cycle with dm_memWrite = 1; loaddata = 0x11223344 with stall never asserted.
- After the word above, SB 0xAB at 0x12 → cycle 1: stall = 1, dm_memWrite = 0. Cycle 2: dm_memWrite = 1, dm_writedata = 0x11AB3344. A subsequent LB from 0x12 gives 0xFFFFFFAB; LBU gives 0x000000AB.
- SH 0x8001 at 0x10 on word 0x11AB3344 → write 0x11AB8001. Then LH 0x10 gives 0xFFFF8001, LHU gives 0x00008001, LH 0x12 gives 0x000011AB.
- Misaligned LW at 0x13 and SH at 0x11 → addr_exc = 1, dm_memWrite = 0, stall = 0, memory unchanged (a following LW 0x10 still returns 0x11AB8001).
- SB at 0x20 with reset asserted in the RMW_WR cycle → no DM write occurs, state IDLE next cycle, word 0x20 remains 0.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared opcode constants, FSM state encoding and request
// classification helpers for the data-memory access unit.
package mem_pkg;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LW   = 4'd1;
  localparam logic [3:0] OP_LH   = 4'd2;
  localparam logic [3:0] OP_LHU  = 4'd3;
  localparam logic [3:0] OP_LB   = 4'd4;
  localparam logic [3:0] OP_LBU  = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SB   = 4'd8;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_t;

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

  function automatic logic is_subword_store(input logic [3:0] op);
    return (op == OP_SH) || (op == OP_SB);
  endfunction

  // Word ops need a 4-byte aligned address, halfword ops a 2-byte one.
  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
    if ((op == OP_LW) || (op == OP_SW))
      return a != 2'b00;
    if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH))
      return a[0];
    return 1'b0;
  endfunction

endpackage

// File: rtl/load_ext.sv
// load_ext: picks the addressed byte/halfword lane out of a DM read word and
// sign- or zero-extends it to 32 bits. Non-load opcodes yield 0.
// Ports:
//   word_i    DM read word (little-endian, lane 0 = [7:0])
//   addr_lo_i address[1:0] of the request
//   op_i      request opcode
//   data_o    extended load result
module load_ext
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [3:0]  op_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    case (op_i)
      OP_LW:   data_o = word_i;
      OP_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  data_o = {16'h0000, half_sel};
      OP_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  data_o = {24'h000000, byte_sel};
      default: data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// dm_access_unit: memory-stage front end for a word-wide data memory.
// Word accesses go straight through; sub-word stores are performed as a
// read (stall cycle) followed by a write of the merged word. Misaligned
// requests raise addr_exc and never touch DM.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   mem_op/pc/address/writedata  pipeline request (held while stall = 1)
//   stall, addr_exc, loaddata    responses to the pipeline
//   dm_address/dm_writedata/dm_memWrite/dm_memRead/dm_pc  to DM
//   dm_readdata           combinational read data from DM
module dm_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        mem_op,
  input  logic [31:0]       pc,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  output logic              stall,
  output logic              addr_exc,
  output logic [DATA_W-1:0] loaddata,
  output logic [ADDR_W-1:0] dm_address,
  output logic [DATA_W-1:0] dm_writedata,
  output logic              dm_memWrite,
  output logic              dm_memRead,
  output logic [31:0]       dm_pc,
  input  logic [DATA_W-1:0] dm_readdata
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] merge_q, merge_d;
  logic [DATA_W-1:0] ext_data;
  logic [DATA_W-1:0] merged;
  logic              misaligned;

  load_ext u_load_ext (
    .word_i    (dm_readdata),
    .addr_lo_i (address[1:0]),
    .op_i      (mem_op),
    .data_o    (ext_data)
  );

  // Read word with the store lane replaced by the right-aligned store data.
  always_comb begin
    merged = dm_readdata;
    if (mem_op == OP_SB)
      merged[{address[1:0], 3'b000} +: 8] = writedata[7:0];
    else
      merged[{address[1], 4'b0000} +: 16] = writedata[15:0];
  end

  always_comb begin
    misaligned   = is_misaligned(mem_op, address[1:0]);
    addr_exc     = misaligned;
    stall        = 1'b0;
    loaddata     = '0;
    dm_address   = {address[ADDR_W-1:2], 2'b00};
    dm_writedata = '0;
    dm_memWrite  = 1'b0;
    dm_memRead   = 1'b0;
    dm_pc        = pc;
    state_d      = state_q;
    merge_d      = merge_q;

    case (state_q)
      IDLE: begin
        if (!misaligned) begin
          if (is_load(mem_op)) begin
            dm_memRead = 1'b1;
            loaddata   = ext_data;
          end else if (mem_op == OP_SW) begin
            dm_memWrite  = 1'b1;
            dm_writedata = writedata;
          end else if (is_subword_store(mem_op)) begin
            dm_memRead = 1'b1;
            stall      = 1'b1;
            merge_d    = merged;
            state_d    = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        dm_memWrite  = !misaligned;
        dm_writedata = merge_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // No DM write and no stall request may escape while reset is held.
    if (reset) begin
      dm_memWrite = 1'b0;
      stall       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
    end
  end

endmodule
